// File: rtl/edge_pkg.sv
// Shared types and constants for the edge detector bank.
//   edge_mode_t : per-channel edge select (off / rise / fall / both)
//   IDLE_LEVEL  : level the input lines rest at, used as the reset value
//   cnt_width() : debounce counter width, never less than one bit
package edge_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  localparam logic IDLE_LEVEL = 1'b1;

  function automatic int unsigned cnt_width(input int unsigned debounce);
    return (debounce > 1) ? $clog2(debounce) : 1;
  endfunction

endpackage

// File: rtl/edge_channel.sv
// One edge detector channel: synchroniser, debounce, edge qualification and the
// sticky pending/overrun flags.
// Ports:
//   i_clk      clock, all state on rising edge
//   i_reset    synchronous active-high reset
//   i_d        raw asynchronous input (idles high)
//   i_mode     edge select, bit 0 = rise, bit 1 = fall
//   i_clr      write-1-to-clear for pending and overrun
//   o_level    debounced level
//   o_pulse    one-cycle qualified edge event, coincident with the new level
//   o_pending  sticky event flag
//   o_overrun  sticky flag for an event seen while pending was already set
module edge_channel
  import edge_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE    = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_d,
  input  logic [1:0] i_mode,
  input  logic       i_clr,
  output logic       o_level,
  output logic       o_pulse,
  output logic       o_pending,
  output logic       o_overrun
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CntW-1:0]        r_cnt;
  logic                   r_level;
  logic                   r_pulse;
  logic                   r_pending;
  logic                   r_overrun;

  logic w_s;
  logic w_update;
  logic w_rise_en;
  logic w_fall_en;
  logic w_qualified;

  always_comb begin
    w_rise_en = 1'b0;
    w_fall_en = 1'b0;
    unique case (edge_mode_t'(i_mode))
      EDGE_OFF:  ;
      EDGE_RISE: w_rise_en = 1'b1;
      EDGE_FALL: w_fall_en = 1'b1;
      EDGE_BOTH: begin
        w_rise_en = 1'b1;
        w_fall_en = 1'b1;
      end
    endcase
    // Only the last synchroniser stage feeds any logic.
    w_s         = r_sync[SYNC_STAGES-1];
    w_update    = (w_s != r_level) && (r_cnt == CntMax);
    // The new level is w_s, so w_s high on an update means a rising edge.
    w_qualified = w_update && (w_s ? w_rise_en : w_fall_en);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync    <= {SYNC_STAGES{IDLE_LEVEL}};
      r_cnt     <= '0;
      r_level   <= IDLE_LEVEL;
      r_pulse   <= 1'b0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};

      if (w_s == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CntMax) begin
        r_level <= w_s;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      r_pulse <= w_qualified;

      // A same-cycle event beats clr for pending; clr always wins for overrun.
      r_pending <= r_pulse | (r_pending & ~i_clr);
      r_overrun <= ~i_clr & (r_overrun | (r_pulse & r_pending));
    end
  end

  assign o_level   = r_level;
  assign o_pulse   = r_pulse;
  assign o_pending = r_pending;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/edge_detect_bank.sv
// Bank of N independent edge detector channels for push-buttons and strobes.
// Ports:
//   clk          clock
//   reset        synchronous active-high reset
//   d[N]         raw asynchronous inputs (idle high)
//   mode[2N]     per-channel edge select, channel i at [2i+1:2i]
//   clr[N]       write-1-to-clear for pending and overrun
//   level[N]     debounced levels
//   pulse[N]     one-cycle edge events
//   pending[N]   sticky event flags
//   overrun[N]   sticky overrun flags
//   any_pending  OR of all pending flags
module edge_detect_bank
  import edge_pkg::*;
#(
  parameter int unsigned N           = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE    = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   d,
  input  logic [2*N-1:0] mode,
  input  logic [N-1:0]   clr,
  output logic [N-1:0]   level,
  output logic [N-1:0]   pulse,
  output logic [N-1:0]   pending,
  output logic [N-1:0]   overrun,
  output logic           any_pending
);

  for (genvar gi = 0; gi < N; gi++) begin : g_ch
    edge_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE    (DEBOUNCE)
    ) u_ch (
      .i_clk     (clk),
      .i_reset   (reset),
      .i_d       (d[gi]),
      .i_mode    (mode[2*gi +: 2]),
      .i_clr     (clr[gi]),
      .o_level   (level[gi]),
      .o_pulse   (pulse[gi]),
      .o_pending (pending[gi]),
      .o_overrun (overrun[gi])
    );
  end

  assign any_pending = |pending;

endmodule

// File: tb/tb_edge_detect_bank.sv
module tb_edge_detect_bank;
  import edge_pkg::*;

  localparam int unsigned N    = 4;
  localparam int unsigned SYNC = 2;
  localparam int unsigned DEB  = 4;

  typedef struct packed {
    logic [N-1:0] level;
    logic [N-1:0] pulse;
    logic [N-1:0] pending;
    logic [N-1:0] overrun;
    logic         any;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   d;
  logic [2*N-1:0] mode;
  logic [N-1:0]   clr;
  logic [N-1:0]   level;
  logic [N-1:0]   pulse;
  logic [N-1:0]   pending;
  logic [N-1:0]   overrun;
  logic           any_pending;

  edge_detect_bank #(
    .N           (N),
    .SYNC_STAGES (SYNC),
    .DEBOUNCE    (DEB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .d           (d),
    .mode        (mode),
    .clr         (clr),
    .level       (level),
    .pulse       (pulse),
    .pending     (pending),
    .overrun     (overrun),
    .any_pending (any_pending)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Stimulus intent, applied to the DUT pins by tick().
  logic           drv_reset = 1'b1;
  logic [N-1:0]   drv_d     = '1;
  logic [2*N-1:0] drv_mode  = '0;
  logic [N-1:0]   drv_clr   = '0;

  // Reference model state: raw input history and synchronised sample window.
  logic [N-1:0] d_hist[$];
  logic [N-1:0] s_hist[$];
  logic [N-1:0] m_level = '1;
  logic [N-1:0] m_pulse = '0;
  logic [N-1:0] m_pend  = '0;
  logic [N-1:0] m_ovr   = '0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, req);
    end
  endtask

  // Model of one rising edge. A level is accepted once the last DEB synchronised
  // samples all disagree with it; samples reach the window SYNC edges after pins.
  task automatic model_step();
    logic [N-1:0] s;
    logic [N-1:0] old_pulse;
    edge_mode_t   m;
    bit           all_diff;
    exp_t         e;
    if (drv_reset) begin
      d_hist.delete();
      s_hist.delete();
      for (int k = 0; k < int'(SYNC); k++) d_hist.push_back('1);
      for (int k = 0; k < int'(DEB); k++) s_hist.push_back('1);
      m_level = '1;
      m_pulse = '0;
      m_pend  = '0;
      m_ovr   = '0;
    end else begin
      s = d_hist[0];
      d_hist.push_back(drv_d);
      void'(d_hist.pop_front());
      s_hist.push_back(s);
      if (s_hist.size() > int'(DEB)) void'(s_hist.pop_front());
      old_pulse = m_pulse;
      for (int ch = 0; ch < int'(N); ch++) begin
        // Flags react to the event that was visible on pulse during this cycle.
        if (old_pulse[ch]) begin
          if (m_pend[ch] && !drv_clr[ch]) m_ovr[ch] = 1'b1;
          else if (drv_clr[ch]) m_ovr[ch] = 1'b0;
          m_pend[ch] = 1'b1;
        end else if (drv_clr[ch]) begin
          m_pend[ch] = 1'b0;
          m_ovr[ch]  = 1'b0;
        end
        all_diff = 1'b1;
        foreach (s_hist[k]) if (s_hist[k][ch] == m_level[ch]) all_diff = 1'b0;
        m = edge_mode_t'(drv_mode[2*ch +: 2]);
        m_pulse[ch] = 1'b0;
        if (all_diff) begin
          m_level[ch] = ~m_level[ch];
          if (m_level[ch]) m_pulse[ch] = (m == EDGE_RISE) || (m == EDGE_BOTH);
          else             m_pulse[ch] = (m == EDGE_FALL) || (m == EDGE_BOTH);
        end
      end
    end
    e.level   = m_level;
    e.pulse   = m_pulse;
    e.pending = m_pend;
    e.overrun = m_ovr;
    e.any     = |m_pend;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      reset = drv_reset;
      d     = drv_d;
      mode  = drv_mode;
      clr   = drv_clr;
      model_step();
    end
  endtask

  task automatic set_mode(input int ch, input edge_mode_t m);
    drv_mode[2*ch +: 2] = m;
  endtask

  // Monitor: each expected entry describes the state after the edge that follows
  // its push, so it is compared at the next falling edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("level", level, e.level);
      check("pulse", pulse, e.pulse);
      check("pending", pending, e.pending);
      check("overrun", overrun, e.overrun);
      check("any_pending", {{(N-1){1'b0}}, any_pending}, {{(N-1){1'b0}}, e.any});
    end
  end

  initial begin
    int guard;
    reset = 1'b1;
    d     = '1;
    mode  = '0;
    clr   = '0;

    // Reset state with all lines idle high.
    drv_reset = 1'b1;
    tick(3);
    drv_reset = 1'b0;
    tick(2);

    // Falling edge on channel 0, then software clear.
    set_mode(0, EDGE_FALL);
    drv_d[0] = 1'b0;
    tick(10);
    drv_clr[0] = 1'b1;
    tick(1);
    drv_clr[0] = 1'b0;
    tick(2);

    // Glitch rejection on channel 1: 3-cycle low rejected, 4-cycle low accepted.
    set_mode(1, EDGE_BOTH);
    drv_d[1] = 1'b0;
    tick(3);
    drv_d[1] = 1'b1;
    tick(8);
    drv_d[1] = 1'b0;
    tick(4);
    drv_d[1] = 1'b1;
    tick(10);

    // Mode coverage on channel 2.
    foreach (drv_mode[i]) ;
    set_mode(2, EDGE_RISE);
    for (int mi = 0; mi < 4; mi++) begin
      case (mi)
        0: set_mode(2, EDGE_RISE);
        1: set_mode(2, EDGE_FALL);
        2: set_mode(2, EDGE_BOTH);
        default: set_mode(2, EDGE_OFF);
      endcase
      drv_d[2] = 1'b0;
      tick(8);
      drv_d[2] = 1'b1;
      tick(8);
    end

    // Overrun on channel 3, then clr racing a third event.
    set_mode(3, EDGE_BOTH);
    drv_d[3] = 1'b0;
    tick(8);
    drv_d[3] = 1'b1;
    tick(8);
    drv_d[3] = 1'b0;
    tick(6);
    drv_clr[3] = 1'b1;
    tick(1);
    drv_clr[3] = 1'b0;
    tick(3);

    // Reset mid-operation while channel 0 is debouncing a fall.
    drv_d     = '1;
    drv_reset = 1'b1;
    tick(1);
    drv_reset = 1'b0;
    tick(2);
    drv_d[0] = 1'b0;
    tick(4);
    drv_reset = 1'b1;
    drv_clr   = '1;
    tick(1);
    drv_reset = 1'b0;
    drv_clr   = '0;
    tick(10);

    // Randomised traffic across all channels.
    for (int c = 0; c < 2500; c++) begin
      for (int ch = 0; ch < int'(N); ch++) begin
        if ($urandom_range(5) == 0) drv_d[ch] = ~drv_d[ch];
        drv_clr[ch] = ($urandom_range(7) == 0);
      end
      if ($urandom_range(39) == 0) drv_mode = 8'($urandom);
      drv_reset = ($urandom_range(299) == 0);
      tick(1);
    end
    drv_reset = 1'b0;
    drv_clr   = '0;
    tick(2);

    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(negedge clk);
      #2;
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d samples left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
